// File: rtl/sccb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_arbiter
//  Description : Two-channel write arbiter in front of an SCCB master. It picks
//                one requester (round-robin or channel-0 priority), latches its
//                register address and value, starts the master, tracks the
//                master's ready flag to completion, and bounds every transfer
//                with a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535,
    parameter int          FIXED_PRIO  = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Req0,
    input  logic       i_Req1,
    input  logic [7:0] i_Addr0,
    input  logic [7:0] i_Addr1,
    input  logic [7:0] i_Data0,
    input  logic [7:0] i_Data1,
    output logic       o_Ack0,
    output logic       o_Ack1,
    output logic       o_Done0,
    output logic       o_Done1,
    output logic       o_Tout0,
    output logic       o_Tout1,
    output logic [7:0] o_SCCB_Addr,
    output logic [7:0] o_SCCB_Data,
    output logic       o_SCCB_fStart,
    input  logic       i_SCCB_fReady,
    output logic       o_Busy,
    output logic       o_Owner
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LATCH     = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5
    } state_t;

    // The timeout fires in the TIMEOUT_CYC-th counted cycle after LATCH.
    localparam logic [15:0] TOUT_LAST = TIMEOUT_CYC - 16'd1;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tout_cnt;
    logic        last_served;
    logic        any_req;
    logic        winner;
    logic        grant;
    logic        active;
    logic        tout_hit;

    assign any_req  = i_Req0 | i_Req1;
    assign grant    = (state == IDLE) && any_req;
    assign active   = (state == START) || (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign tout_hit = active && (tout_cnt == TOUT_LAST);

    // Winner selection: channel 0 priority, or alternate when both request.
    always_comb begin
        winner = 1'b0;
        if (FIXED_PRIO != 0) begin
            winner = ~i_Req0;
        end else if (i_Req0 && i_Req1) begin
            winner = ~last_served;
        end else begin
            winner = ~i_Req0;
        end
    end

    // State register; reset drops straight to IDLE so all pulses vanish at once.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pulse outputs; a timeout overrides fStart/Done in the same cycle.
    always_comb begin
        state_nxt     = state;
        o_Ack0        = 1'b0;
        o_Ack1        = 1'b0;
        o_Done0       = 1'b0;
        o_Done1       = 1'b0;
        o_Tout0       = 1'b0;
        o_Tout1       = 1'b0;
        o_SCCB_fStart = 1'b0;
        o_Busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                o_Ack0    = ~o_Owner;
                o_Ack1    = o_Owner;
                state_nxt = START;
            end
            START: begin
                if (tout_hit) begin
                    o_Tout0   = ~o_Owner;
                    o_Tout1   = o_Owner;
                    state_nxt = IDLE;
                end else if (i_SCCB_fReady) begin
                    o_SCCB_fStart = 1'b1;
                    state_nxt     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tout_hit) begin
                    o_Tout0   = ~o_Owner;
                    o_Tout1   = o_Owner;
                    state_nxt = IDLE;
                end else if (!i_SCCB_fReady) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tout_hit) begin
                    o_Tout0   = ~o_Owner;
                    o_Tout1   = o_Owner;
                    state_nxt = IDLE;
                end else if (i_SCCB_fReady) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_Done0   = ~o_Owner;
                o_Done1   = o_Owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant capture: owner, pointer and the winner's address/value are taken
    // on the IDLE exit so they are already stable during the Ack cycle.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Owner     <= 1'b0;
            last_served <= 1'b1;
            o_SCCB_Addr <= 8'h00;
            o_SCCB_Data <= 8'h00;
        end else if (grant) begin
            o_Owner     <= winner;
            last_served <= winner;
            o_SCCB_Addr <= winner ? i_Addr1 : i_Addr0;
            o_SCCB_Data <= winner ? i_Data1 : i_Data0;
        end
    end

    // Transfer watchdog: cleared in LATCH, counts every START/WAIT_* cycle.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            tout_cnt <= 16'd0;
        end else if (state == LATCH) begin
            tout_cnt <= 16'd0;
        end else if (active) begin
            tout_cnt <= tout_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sccb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sccb_arbiter
//  Description : Self-checking bench for sccb_arbiter. A round-robin and a
//                fixed-priority instance share one stimulus stream; expected
//                per-cycle outputs come from a transaction-level model that
//                works out each transfer's milestones from the ready schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_arbiter;

    localparam int NMAX = 640;
    localparam int T    = 100;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, rdy;
    logic [7:0] a0, a1, d0, d1;

    logic       rr_ack0, rr_ack1, rr_done0, rr_done1, rr_tout0, rr_tout1, rr_fs, rr_busy, rr_own;
    logic [7:0] rr_addr, rr_data;
    logic       fp_ack0, fp_ack1, fp_done0, fp_done1, fp_tout0, fp_tout1, fp_fs, fp_busy, fp_own;
    logic [7:0] fp_addr, fp_data;

    sccb_arbiter #(.TIMEOUT_CYC(16'd100), .FIXED_PRIO(0)) dut_rr (
        .i_Clk(clk), .i_Rst(rst_n),
        .i_Req0(req0), .i_Req1(req1),
        .i_Addr0(a0), .i_Addr1(a1), .i_Data0(d0), .i_Data1(d1),
        .o_Ack0(rr_ack0), .o_Ack1(rr_ack1), .o_Done0(rr_done0), .o_Done1(rr_done1),
        .o_Tout0(rr_tout0), .o_Tout1(rr_tout1),
        .o_SCCB_Addr(rr_addr), .o_SCCB_Data(rr_data), .o_SCCB_fStart(rr_fs),
        .i_SCCB_fReady(rdy), .o_Busy(rr_busy), .o_Owner(rr_own)
    );

    sccb_arbiter #(.TIMEOUT_CYC(16'd100), .FIXED_PRIO(1)) dut_fp (
        .i_Clk(clk), .i_Rst(rst_n),
        .i_Req0(req0), .i_Req1(req1),
        .i_Addr0(a0), .i_Addr1(a1), .i_Data0(d0), .i_Data1(d1),
        .o_Ack0(fp_ack0), .o_Ack1(fp_ack1), .o_Done0(fp_done0), .o_Done1(fp_done1),
        .o_Tout0(fp_tout0), .o_Tout1(fp_tout1),
        .o_SCCB_Addr(fp_addr), .o_SCCB_Data(fp_data), .o_SCCB_fStart(fp_fs),
        .i_SCCB_fReady(rdy), .o_Busy(fp_busy), .o_Owner(fp_own)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus schedule (one entry per cycle after reset release).
    logic       s_req0 [NMAX];
    logic       s_req1 [NMAX];
    logic       s_rdy  [NMAX];
    logic [7:0] s_a0 [NMAX];
    logic [7:0] s_a1 [NMAX];
    logic [7:0] s_d0 [NMAX];
    logic [7:0] s_d1 [NMAX];

    // Expected vector per instance: {addr,data,owner,busy,fstart,tout1,tout0,done1,done0,ack1,ack0}
    logic [24:0] exp_v [2][NMAX];

    int n_pass;
    int n_chk;

    // Observations of the round-robin instance (cycle numbers) and both grant streams.
    int ack0_c[$], ack1_c[$], fs_c[$], fs_ad[$], done0_c[$], done1_c[$], tout0_c[$];
    int g_rr[$], g_fp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [24:0] pack(input logic ak0, ak1, dn0, dn1, to0, to1, fs, bsy, own,
                                         input logic [7:0] dat, adr);
        return {adr, dat, own, bsy, fs, to1, to0, dn1, dn0, ak1, ak0};
    endfunction

    function automatic logic [24:0] obs_rr();
        return pack(rr_ack0, rr_ack1, rr_done0, rr_done1, rr_tout0, rr_tout1, rr_fs, rr_busy, rr_own, rr_data, rr_addr);
    endfunction

    function automatic logic [24:0] obs_fp();
        return pack(fp_ack0, fp_ack1, fp_done0, fp_done1, fp_tout0, fp_tout1, fp_fs, fp_busy, fp_own, fp_data, fp_addr);
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < NMAX; i++) begin
            s_req0[i] = 1'b0; s_req1[i] = 1'b0; s_rdy[i] = 1'b1;
            s_a0[i] = 8'($urandom); s_a1[i] = 8'($urandom);
            s_d0[i] = 8'($urandom); s_d1[i] = 8'($urandom);
        end
    endtask

    task automatic gen_random();
        bit r0, r1, lvl;
        int i, n;
        r0 = 1'b0; r1 = 1'b0;
        clear_stim();
        for (int k = 0; k < NMAX; k++) begin
            r0 = r0 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 7) == 0);
            r1 = r1 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 7) == 0);
            s_req0[k] = r0; s_req1[k] = r1;
        end
        i = 0; lvl = 1'b1;
        while (i < NMAX) begin
            if (lvl) n = int'($urandom_range(1, 8));
            else if ($urandom_range(0, 7) == 0) n = int'($urandom_range(90, 130));
            else n = int'($urandom_range(1, 12));
            for (int j = 0; j < n && i < NMAX; j++) begin
                s_rdy[i] = lvl;
                i++;
            end
            lvl = ~lvl;
        end
    endtask

    // Transaction-level reference: for each grant, locate the ready rise that
    // starts the master, its fall, and the next rise; whichever milestone is
    // missing within T counted cycles after the Ack turns the transfer into a timeout.
    task automatic build_model(input int k, input bit fixed, input int len);
        int t, L, cap, c, d, e, ai, di, ti;
        bit last, w;
        for (int i = 0; i < NMAX; i++) exp_v[k][i] = '0;
        last = 1'b1;
        t = 0;
        while (t < len) begin
            if (!s_req0[t] && !s_req1[t]) begin
                t++;
                continue;
            end
            if (fixed) w = ~s_req0[t];
            else if (s_req0[t] && s_req1[t]) w = ~last;
            else w = ~s_req0[t];
            last = w;
            ai = w ? 1 : 0; di = w ? 3 : 2; ti = w ? 5 : 4;
            L = t + 1;
            cap = L + T;
            exp_v[k][L][ai] = 1'b1;
            for (int j = L; j < NMAX; j++) begin
                exp_v[k][j][8]     = w;
                exp_v[k][j][16:9]  = w ? s_d1[t] : s_d0[t];
                exp_v[k][j][24:17] = w ? s_a1[t] : s_a0[t];
            end
            c = L + 1;
            while (c < cap && !s_rdy[c]) c++;
            d = c + 1;
            while (d < cap && s_rdy[d]) d++;
            e = d + 1;
            while (e < cap && !s_rdy[e]) e++;
            if (e < cap) begin
                exp_v[k][c][6]  = 1'b1;
                exp_v[k][e + 1][di] = 1'b1;
                for (int j = L; j <= e + 1; j++) exp_v[k][j][7] = 1'b1;
                t = e + 2;
            end else begin
                if (c < cap) exp_v[k][c][6] = 1'b1;
                exp_v[k][cap][ti] = 1'b1;
                for (int j = L; j <= cap; j++) exp_v[k][j][7] = 1'b1;
                t = cap + 1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rdy = 1'b1;
        a0 = 8'h00; a1 = 8'h00; d0 = 8'h00; d1 = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs one scenario from reset; optionally asserts reset mid-run at abort_at.
    task automatic run_scn(input string name, input int len, input int abort_at);
        ack0_c.delete(); ack1_c.delete(); fs_c.delete(); fs_ad.delete();
        done0_c.delete(); done1_c.delete(); tout0_c.delete(); g_rr.delete(); g_fp.delete();
        build_model(0, 1'b0, len);
        build_model(1, 1'b1, len);
        do_reset();
        for (int i = 0; i < len; i++) begin
            req0 = s_req0[i]; req1 = s_req1[i]; rdy = s_rdy[i];
            a0 = s_a0[i]; a1 = s_a1[i]; d0 = s_d0[i]; d1 = s_d1[i];
            @(negedge clk);
            chk($sformatf("%s_rr_c%0d", name, i), 32'(obs_rr()), 32'(exp_v[0][i]));
            chk($sformatf("%s_fp_c%0d", name, i), 32'(obs_fp()), 32'(exp_v[1][i]));
            if (rr_ack0) ack0_c.push_back(i);
            if (rr_ack1) ack1_c.push_back(i);
            if (rr_fs) begin
                fs_c.push_back(i);
                fs_ad.push_back(int'({rr_addr, rr_data}));
            end
            if (rr_done0) done0_c.push_back(i);
            if (rr_done1) done1_c.push_back(i);
            if (rr_tout0) tout0_c.push_back(i);
            if (rr_ack0 || rr_ack1) g_rr.push_back(int'(rr_ack1));
            if (fp_ack0 || fp_ack1) g_fp.push_back(int'(fp_ack1));
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async_rr", 32'(obs_rr()), 32'd0);
                chk("rst_async_fp", 32'(obs_fp()), 32'd0);
                req0 = 1'b1; rdy = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_hold_rr", 32'(obs_rr()), 32'd0);
                    chk("rst_hold_fp", 32'(obs_fp()), 32'd0);
                end
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n1;
        n_pass = 0;
        n_chk  = 0;
        rst_n  = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rdy = 1'b1;
        a0 = 8'h00; a1 = 8'h00; d0 = 8'h00; d1 = 8'h00;
        #2;
        chk("reset_rr", 32'(obs_rr()), 32'd0);
        chk("reset_fp", 32'(obs_fp()), 32'd0);

        // Single ch0 write, master busy for 20 cycles.
        clear_stim();
        s_req0[0] = 1'b1; s_req0[1] = 1'b1;
        s_a0[0] = 8'h12; s_d0[0] = 8'h80; s_a0[1] = 8'h12; s_d0[1] = 8'h80;
        for (int i = 3; i <= 22; i++) s_rdy[i] = 1'b0;
        run_scn("single", 40, -1);
        chk("single_ack0_cyc", (ack0_c.size() > 0) ? ack0_c[0] : -1, 1);
        chk("single_fs_cyc", (fs_c.size() > 0) ? fs_c[0] : -1, 2);
        chk("single_fs_addrdata", (fs_ad.size() > 0) ? fs_ad[0] : -1, 32'h1280);
        chk("single_done0_cnt", done0_c.size(), 1);
        chk("single_done0_cyc", (done0_c.size() > 0) ? done0_c[0] : -1, 24);
        chk("single_tout0_cnt", tout0_c.size(), 0);

        // Both channels held: round-robin alternates, fixed priority keeps ch0.
        clear_stim();
        for (int i = 0; i < 60; i++) begin
            s_req0[i] = 1'b1; s_req1[i] = 1'b1;
            s_rdy[i]  = ((i % 4) != 3);
        end
        run_scn("both", 60, -1);
        chk("rr_grant0", (g_rr.size() > 0) ? g_rr[0] : -1, 0);
        chk("rr_grant1", (g_rr.size() > 1) ? g_rr[1] : -1, 1);
        chk("rr_grant2", (g_rr.size() > 2) ? g_rr[2] : -1, 0);
        n1 = 0;
        foreach (g_fp[j]) n1 += g_fp[j];
        chk("fp_grants_seen", (g_fp.size() >= 3), 1);
        chk("fp_ch1_acks", n1, 0);

        // Timeout with the master stuck busy, then a request stalled in START.
        clear_stim();
        s_req0[0] = 1'b1; s_req0[1] = 1'b1;
        s_req1[102] = 1'b1; s_req1[103] = 1'b1;
        for (int i = 3; i <= 108; i++) s_rdy[i] = 1'b0;
        for (int i = 110; i <= 115; i++) s_rdy[i] = 1'b0;
        run_scn("tout", 130, -1);
        chk("tout0_cnt", tout0_c.size(), 1);
        chk("tout0_cyc", (tout0_c.size() > 0) ? tout0_c[0] : -1, 101);
        chk("tout_no_done0", done0_c.size(), 0);
        chk("tout_ack1_cyc", (ack1_c.size() > 0) ? ack1_c[0] : -1, 103);
        chk("tout_fs_cnt", fs_c.size(), 2);
        chk("tout_fs2_cyc", (fs_c.size() > 1) ? fs_c[1] : -1, 109);
        chk("tout_done1_cyc", (done1_c.size() > 0) ? done1_c[0] : -1, 117);

        // Reset in WAIT_DONE, then a lone ch1 request after release.
        clear_stim();
        s_req0[0] = 1'b1; s_req0[1] = 1'b1;
        for (int i = 3; i <= 30; i++) s_rdy[i] = 1'b0;
        run_scn("abort", 40, 10);
        chk("abort_no_done", done0_c.size(), 0);
        clear_stim();
        s_req1[0] = 1'b1; s_req1[1] = 1'b1;
        for (int i = 3; i <= 5; i++) s_rdy[i] = 1'b0;
        run_scn("after_rst", 20, -1);
        chk("after_rst_ack1_cyc", (ack1_c.size() > 0) ? ack1_c[0] : -1, 1);

        // Randomised traffic against the reference model.
        for (int r = 0; r < 5; r++) begin
            gen_random();
            run_scn($sformatf("rand%0d", r), 400, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
